// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry FIFO of
// {pc, instr, pc_misalign, bus_err} with exception hold and redirect flush.
module instr_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         if_valid_i,
    output logic                         if_ready_o,
    input  logic [PC_WIDTH-1:0]          if_pc_i,
    input  logic [INSTR_WIDTH-1:0]       if_instr_i,
    input  logic                         if_pc_misalign_i,
    input  logic                         if_bus_err_i,
    output logic                         id_valid_o,
    input  logic                         id_ready_i,
    output logic [PC_WIDTH-1:0]          id_pc_o,
    output logic [INSTR_WIDTH-1:0]       id_instr_o,
    output logic                         id_pc_misalign_o,
    output logic                         id_bus_err_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
        logic                   pc_misalign;
        logic                   bus_err;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            excp_hold_q, excp_hold_d;
    logic            push_c, pop_c, not_empty_c;
    entry_t          head_c;

    // Handshake qualifiers depend only on registered state and flush.
    assign not_empty_c = (count_q != '0);
    assign if_ready_o  = !flush_i && !excp_hold_q && (count_q < CW'(DEPTH));
    assign id_valid_o  = !flush_i && not_empty_c;
    assign push_c      = if_valid_i && if_ready_o;
    assign pop_c       = id_valid_o && id_ready_i;

    // Head presentation, zeroed while empty.
    always_comb begin
        head_c = '0;
        if (not_empty_c) begin
            head_c = mem[rd_ptr_q];
        end
    end

    assign id_pc_o          = head_c.pc;
    assign id_instr_o       = head_c.instr;
    assign id_pc_misalign_o = head_c.pc_misalign;
    assign id_bus_err_o     = head_c.bus_err;
    assign count_o          = count_q;

    // Next-state for pointers, occupancy and exception hold.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        excp_hold_d = excp_hold_q;
        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            excp_hold_d = 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                if (if_pc_misalign_i || if_bus_err_i) begin
                    excp_hold_d = 1'b1;
                end
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            excp_hold_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            excp_hold_q <= excp_hold_d;
        end
    end

    // Storage needs no reset; occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= '{pc:          if_pc_i,
                               instr:       if_instr_i,
                               pc_misalign: if_pc_misalign_i,
                               bus_err:     if_bus_err_i};
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push_c && (count_q == CW'(DEPTH))));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop_c && (count_q == '0)));

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (DEPTH=4, 32-bit pc/instr).
module tb_instr_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] if_pc_i;
    logic [31:0] if_instr_i;
    logic        if_pc_misalign_i;
    logic        if_bus_err_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_pc_misalign_o;
    logic        id_bus_err_o;
    logic [2:0]  count_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    instr_queue #(.DEPTH(4), .PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .if_valid_i       (if_valid_i),
        .if_ready_o       (if_ready_o),
        .if_pc_i          (if_pc_i),
        .if_instr_i       (if_instr_i),
        .if_pc_misalign_i (if_pc_misalign_i),
        .if_bus_err_i     (if_bus_err_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_pc_o          (id_pc_o),
        .id_instr_o       (id_instr_o),
        .id_pc_misalign_o (id_pc_misalign_o),
        .id_bus_err_o     (id_bus_err_o),
        .count_o          (count_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, then let combinational outputs settle.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic mis, input logic berr, input logic rdy, input logic fl);
        if_valid_i       = v;
        if_pc_i          = pc;
        if_instr_i       = ins;
        if_pc_misalign_i = mis;
        if_bus_err_i     = berr;
        id_ready_i       = rdy;
        flush_i          = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] nxt;
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        idle();

        // 1: reset state
        chk("rst_valid", 64'(id_valid_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_ready", 64'(if_ready_o), 64'd1);
        chk("rst_pc", 64'(id_pc_o), 64'd0);
        chk("rst_instr", 64'(id_instr_o), 64'd0);

        // 2: single push, visible after one edge
        drive(1'b1, 32'h100, 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_ready", 64'(if_ready_o), 64'd1);
        chk("t2_no_bypass", 64'(id_valid_o), 64'd0);
        tick();
        idle();
        chk("t2_valid", 64'(id_valid_o), 64'd1);
        chk("t2_pc", 64'(id_pc_o), 64'h100);
        chk("t2_instr", 64'(id_instr_o), 64'h13);
        chk("t2_count", 64'(count_o), 64'd1);

        // 3: fill, then concurrent push/pop across pointer wrap
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        chk("t3_full_count", 64'(count_o), 64'd4);
        chk("t3_full_ready", 64'(if_ready_o), 64'd0);
        nxt = 32'h110;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, nxt, 32'h00000013, 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("t3_pc%0d", i), 64'(id_pc_o), 64'(32'h100 + 32'(4 * i)));
            chk($sformatf("t3_cnt%0d", i), 64'(count_o), (i == 0) ? 64'd4 : 64'd3);
            chk($sformatf("t3_rdy%0d", i), 64'(if_ready_o), (i == 0) ? 64'd0 : 64'd1);
            tick();
            if (i != 0) nxt = nxt + 32'd4;
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("t3_drain%0d", i), 64'(id_pc_o), 64'(32'h120 + 32'(4 * i)));
            tick();
        end
        idle();
        chk("t3_empty_count", 64'(count_o), 64'd0);
        chk("t3_empty_valid", 64'(id_valid_o), 64'd0);
        chk("t3_empty_pc", 64'(id_pc_o), 64'd0);

        // 4: bus error entry holds fetch
        drive(1'b1, 32'h200, 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h204, 32'h00000013, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h208, 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_hold_ready", 64'(if_ready_o), 64'd0);
        chk("t4_count", 64'(count_o), 64'd2);
        tick();
        chk("t4_count_held", 64'(count_o), 64'd2);
        drive(1'b1, 32'h208, 32'h00000013, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_pc0", 64'(id_pc_o), 64'h200);
        chk("t4_berr0", 64'(id_bus_err_o), 64'd0);
        tick();
        chk("t4_pc1", 64'(id_pc_o), 64'h204);
        chk("t4_berr1", 64'(id_bus_err_o), 64'd1);
        tick();
        chk("t4_drained_count", 64'(count_o), 64'd0);
        chk("t4_drained_valid", 64'(id_valid_o), 64'd0);
        chk("t4_drained_ready", 64'(if_ready_o), 64'd0);
        tick();
        chk("t4_still_empty", 64'(count_o), 64'd0);

        // flush releases the hold; misalign entry also holds
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        chk("fl_ready", 64'(if_ready_o), 64'd1);
        chk("fl_count", 64'(count_o), 64'd0);
        drive(1'b1, 32'h280, 32'h00000013, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("mis_pc", 64'(id_pc_o), 64'h280);
        chk("mis_flag", 64'(id_pc_misalign_o), 64'd1);
        chk("mis_berr", 64'(id_bus_err_o), 64'd0);
        chk("mis_ready", 64'(if_ready_o), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // 5: flush blocks both handshakes and empties the queue
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h30C, 32'h00000013, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5_flush_ready", 64'(if_ready_o), 64'd0);
        chk("t5_flush_valid", 64'(id_valid_o), 64'd0);
        chk("t5_pre_count", 64'(count_o), 64'd3);
        tick();
        idle();
        chk("t5_count", 64'(count_o), 64'd0);
        chk("t5_ready", 64'(if_ready_o), 64'd1);
        chk("t5_valid", 64'(id_valid_o), 64'd0);

        // 6: reset while full and holding, with flush also asserted
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 32'h00000013, (i == 3), 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        chk("t6_full", 64'(count_o), 64'd4);
        chk("t6_hold_ready", 64'(if_ready_o), 64'd0);
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        idle();
        chk("t6_count", 64'(count_o), 64'd0);
        chk("t6_ready", 64'(if_ready_o), 64'd1);
        chk("t6_valid", 64'(id_valid_o), 64'd0);
        drive(1'b1, 32'h500, 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("t6_post_count", 64'(count_o), 64'd1);
        chk("t6_post_pc", 64'(id_pc_o), 64'h500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
